// File: rtl/write_back_buffer_pkg.sv
// rtl/write_back_buffer_pkg.sv - shared FSM encoding and block geometry for the write-back buffer
package write_back_buffer_pkg;
  localparam int WBB_OFFSET_W = 5;
  localparam int WBB_BLOCK_W  = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WR = 2'd2,
    RESP   = 2'd3
  } wbb_state_t;
endpackage

// File: rtl/write_back_buffer_entry_store.sv
// rtl/write_back_buffer_entry_store.sv - circular block FIFO with parallel address match, merge and pop
module wb_entry_store
  import write_back_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 11,
  parameter int BLOCK_W = WBB_BLOCK_W,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit,
  output logic [PTR_W-1:0]   hit_idx,
  output logic [BLOCK_W-1:0] hit_data,
  input  logic               enq,
  input  logic [TAG_W-1:0]   enq_tag,
  input  logic [BLOCK_W-1:0] enq_data,
  input  logic               merge,
  input  logic [PTR_W-1:0]   merge_idx,
  input  logic [BLOCK_W-1:0] merge_data,
  input  logic               pop,
  output logic [TAG_W-1:0]   head_tag,
  output logic [BLOCK_W-1:0] head_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);
  logic [TAG_W-1:0]   tags [DEPTH];
  logic [BLOCK_W-1:0] data [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               enq_ok;
  logic               pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign enq_ok    = enq && !full;
  assign pop_ok    = pop && !empty;
  assign head_tag  = tags[head];
  assign head_data = data[head];

  // At most one valid entry per block address, so the match needs no priority.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tags[i] == lookup_tag) begin
        hit      = 1'b1;
        hit_idx  = PTR_W'(i);
        hit_data = data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      if (enq_ok) begin
        tags[tail]  <= enq_tag;
        data[tail]  <= enq_data;
        valid[tail] <= 1'b1;
        tail        <= ptr_inc(tail);
      end
      if (merge) begin
        data[merge_idx] <= merge_data;
      end
      if (pop_ok) begin
        valid[head] <= 1'b0;
        head        <= ptr_inc(head);
      end
      if (enq_ok && !pop_ok) begin
        count <= count + 1'b1;
        empty <= 1'b0;
      end else if (pop_ok && !enq_ok) begin
        count <= count - 1'b1;
        empty <= (count == CNT_W'(1));
      end
    end
  end
endmodule

// File: rtl/write_back_buffer.sv
// rtl/write_back_buffer.sv - write-back buffer between cache and main memory with read forwarding
module write_back_buffer
  import write_back_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = WBB_OFFSET_W,
  parameter int BLOCK_W  = WBB_BLOCK_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cacheAccess,
  input  logic                         cacheRead,
  input  logic                         cacheWrite,
  input  logic [ADDR_W-1:0]            cacheAddress,
  input  logic [BLOCK_W-1:0]           cacheWblock,
  output logic [BLOCK_W-1:0]           cacheRblock,
  output logic                         cacheReady,
  output logic                         mainMaccess,
  output logic                         mainRead,
  output logic                         mainWrite,
  output logic [ADDR_W-1:0]            mainAddress,
  output logic [BLOCK_W-1:0]           mainWblock,
  input  logic [BLOCK_W-1:0]           mainRblock,
  input  logic                         mainMready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int PTR_W = $clog2(DEPTH);

  wbb_state_t         state, state_d;
  logic [BLOCK_W-1:0] rblock_d, wblock_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               ready_d, maccess_d, read_d, write_d;
  logic               enq, merge, pop, hit, full;
  logic [PTR_W-1:0]   hit_idx;
  logic [BLOCK_W-1:0] hit_data, head_data;
  logic [TAG_W-1:0]   head_tag, cache_tag;
  logic               req_rd, req_wr;
  logic               unused_offset;

  assign cache_tag     = cacheAddress[ADDR_W-1:OFFSET_W];
  assign unused_offset = ^cacheAddress[OFFSET_W-1:0];
  assign req_rd        = cacheAccess && cacheRead && !cacheWrite;
  assign req_wr        = cacheAccess && cacheWrite && !cacheRead;

  wb_entry_store #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .BLOCK_W (BLOCK_W)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .lookup_tag (cache_tag),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_data   (hit_data),
    .enq        (enq),
    .enq_tag    (cache_tag),
    .enq_data   (cacheWblock),
    .merge      (merge),
    .merge_idx  (hit_idx),
    .merge_data (cacheWblock),
    .pop        (pop),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    state_d   = state;
    rblock_d  = cacheRblock;
    ready_d   = 1'b0;
    maccess_d = mainMaccess;
    read_d    = mainRead;
    write_d   = mainWrite;
    addr_d    = mainAddress;
    wblock_d  = mainWblock;
    enq       = 1'b0;
    merge     = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (req_wr && (hit || !full)) begin
          merge   = hit;
          enq     = !hit;
          ready_d = 1'b1;
          state_d = RESP;
        end else if (req_rd && hit) begin
          rblock_d = hit_data;
          ready_d  = 1'b1;
          state_d  = RESP;
        end else if (req_rd) begin
          maccess_d = 1'b1;
          read_d    = 1'b1;
          addr_d    = {cache_tag, {OFFSET_W{1'b0}}};
          state_d   = MEM_RD;
        end else if (req_wr || !empty) begin
          // A write blocked by a full buffer stays pending while the head drains.
          maccess_d = 1'b1;
          write_d   = 1'b1;
          addr_d    = {head_tag, {OFFSET_W{1'b0}}};
          wblock_d  = head_data;
          state_d   = MEM_WR;
        end
      end
      MEM_RD: begin
        if (mainMready) begin
          maccess_d = 1'b0;
          read_d    = 1'b0;
          rblock_d  = mainRblock;
          ready_d   = 1'b1;
          state_d   = RESP;
        end
      end
      MEM_WR: begin
        if (mainMready) begin
          maccess_d = 1'b0;
          write_d   = 1'b0;
          pop       = 1'b1;
          state_d   = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cacheRblock <= '0;
      cacheReady  <= 1'b0;
      mainMaccess <= 1'b0;
      mainRead    <= 1'b0;
      mainWrite   <= 1'b0;
      mainAddress <= '0;
      mainWblock  <= '0;
    end else begin
      state       <= state_d;
      cacheRblock <= rblock_d;
      cacheReady  <= ready_d;
      mainMaccess <= maccess_d;
      mainRead    <= read_d;
      mainWrite   <= write_d;
      mainAddress <= addr_d;
      mainWblock  <= wblock_d;
    end
  end
endmodule

// File: tb/tb_write_back_buffer.sv
// tb/tb_write_back_buffer.sv - directed self-checking bench for write_back_buffer
module tb_write_back_buffer;
  logic         clk;
  logic         reset;
  logic         cacheAccess, cacheRead, cacheWrite;
  logic [15:0]  cacheAddress;
  logic [255:0] cacheWblock, cacheRblock;
  logic         cacheReady;
  logic         mainMaccess, mainRead, mainWrite;
  logic [15:0]  mainAddress;
  logic [255:0] mainWblock, mainRblock;
  logic         mainMready;
  logic [2:0]   count;
  logic         empty;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           mem_lat  = 5;
  int           lat_cnt  = 0;
  logic [255:0] mem_rdata = '0;
  logic         op_rd   [$];
  logic [15:0]  op_addr [$];
  logic [255:0] op_data [$];

  localparam logic [255:0] DA = {8{32'hAAAA_0001}};
  localparam logic [255:0] DB = {8{32'hBBBB_0002}};
  localparam logic [255:0] DR = {8{32'h1234_5678}};

  write_back_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .cacheAccess  (cacheAccess),
    .cacheRead    (cacheRead),
    .cacheWrite   (cacheWrite),
    .cacheAddress (cacheAddress),
    .cacheWblock  (cacheWblock),
    .cacheRblock  (cacheRblock),
    .cacheReady   (cacheReady),
    .mainMaccess  (mainMaccess),
    .mainRead     (mainRead),
    .mainWrite    (mainWrite),
    .mainAddress  (mainAddress),
    .mainWblock   (mainWblock),
    .mainRblock   (mainRblock),
    .mainMready   (mainMready),
    .count        (count),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: pulses mainMready mem_lat cycles after a request appears and logs the transfer.
  initial begin
    mainMready = 1'b0;
    mainRblock = '0;
    forever begin
      @(negedge clk);
      mainMready = 1'b0;
      if (reset || !mainMaccess) begin
        lat_cnt = 0;
      end else if (lat_cnt >= mem_lat - 1) begin
        mainMready = 1'b1;
        mainRblock = mem_rdata;
        op_rd.push_back(mainRead);
        op_addr.push_back(mainAddress);
        op_data.push_back(mainWblock);
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cache_req(input logic rd, input logic [15:0] addr, input logic [255:0] wdata,
                           output int waited);
    cacheAccess  = 1'b1;
    cacheRead    = rd;
    cacheWrite   = !rd;
    cacheAddress = addr;
    cacheWblock  = wdata;
    waited = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (cacheReady) begin
        waited = i;
        break;
      end
    end
    check_eq("req_done", 256'(waited > 0), 256'(1));
  endtask

  task automatic cache_idle();
    cacheAccess = 1'b0;
    cacheRead   = 1'b0;
    cacheWrite  = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (empty && !mainMaccess) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 256'(ok), 256'(1));
  endtask

  task automatic expect_op(input string tag, input logic rd, input logic [15:0] addr,
                           input logic [255:0] data);
    if (op_addr.size() == 0) begin
      check_eq({tag, "_present"}, 256'(0), 256'(1));
    end else begin
      check_eq({tag, "_rd"}, 256'(op_rd.pop_front()), 256'(rd));
      check_eq({tag, "_addr"}, 256'(op_addr.pop_front()), 256'(addr));
      if (rd) void'(op_data.pop_front());
      else check_eq({tag, "_data"}, op_data.pop_front(), data);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   w;
    logic seen;
    reset        = 1'b1;
    cacheAccess  = 1'b0;
    cacheRead    = 1'b0;
    cacheWrite   = 1'b0;
    cacheAddress = '0;
    cacheWblock  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rblock", cacheRblock, '0);
    check_eq("rst_ready", 256'(cacheReady), 256'(0));
    check_eq("rst_main_ctl", 256'({mainMaccess, mainRead, mainWrite}), 256'(0));
    check_eq("rst_main_addr", 256'(mainAddress), 256'(0));
    check_eq("rst_main_wblock", mainWblock, '0);
    check_eq("rst_count", 256'(count), 256'(0));
    check_eq("rst_empty", 256'(empty), 256'(1));
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | mainMaccess;
    end
    check_eq("idle_no_maccess", 256'(seen), 256'(0));

    // Read and write both high, then both low: neither is a request.
    cacheAccess  = 1'b1;
    cacheRead    = 1'b1;
    cacheWrite   = 1'b1;
    cacheAddress = 16'h1000;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | cacheReady | mainMaccess;
    end
    cacheRead  = 1'b0;
    cacheWrite = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | cacheReady | mainMaccess;
    end
    check_eq("bad_req_ignored", 256'(seen), 256'(0));
    check_eq("bad_req_count", 256'(count), 256'(0));
    cache_idle();

    // Single write then background drain.
    mem_lat = 5;
    cache_req(1'b0, 16'h1000, DA, w);
    check_eq("wr_latency", 256'(w), 256'(1));
    check_eq("wr_count", 256'(count), 256'(1));
    check_eq("wr_empty", 256'(empty), 256'(0));
    cache_idle();
    wait_drained("wr_drained");
    expect_op("wr_drain", 1'b0, 16'h1000, DA);
    check_eq("wr_count_after", 256'(count), 256'(0));

    // Read hit on a queued entry; the request is presented in the RESP cycle.
    cache_req(1'b0, 16'h1000, DA, w);
    cache_req(1'b1, 16'h1000, '0, w);
    check_eq("rhit_latency", 256'(w), 256'(2));
    check_eq("rhit_data", cacheRblock, DA);
    check_eq("rhit_no_mem", 256'(op_addr.size()), 256'(0));
    cache_idle();
    wait_drained("rhit_drained");
    expect_op("rhit_drain", 1'b0, 16'h1000, DA);

    // Merge into the same block; offset bits ignored.
    cache_req(1'b0, 16'h1000, DA, w);
    cache_req(1'b0, 16'h101F, DB, w);
    check_eq("merge_count", 256'(count), 256'(1));
    cache_idle();
    wait_drained("merge_drained");
    expect_op("merge_drain", 1'b0, 16'h1000, DB);
    check_eq("merge_single", 256'(op_addr.size()), 256'(0));

    // Fill, overflow and wrap across 12 distinct blocks.
    mem_lat = 2;
    for (int i = 0; i < 12; i++) begin
      cache_req(1'b0, 16'((i + 1) << 12), {8{32'hD000_0000 + 32'(i)}}, w);
      check_eq($sformatf("fill%0d_count", i), 256'(count), 256'((i < 4) ? i + 1 : 4));
      if (i >= 4) begin
        check_eq($sformatf("fill%0d_waited", i), 256'(w > 2), 256'(1));
        expect_op($sformatf("fill%0d_drain", i), 1'b0, 16'((i - 3) << 12),
                  {8{32'hD000_0000 + 32'(i - 4)}});
      end
    end
    cache_idle();
    wait_drained("fill_drained");
    for (int i = 8; i < 12; i++) begin
      expect_op($sformatf("tail%0d_drain", i), 1'b0, 16'((i + 1) << 12),
                {8{32'hD000_0000 + 32'(i)}});
    end
    check_eq("fill_q_done", 256'(op_addr.size()), 256'(0));

    // Read miss issued while a drain is in flight.
    mem_lat   = 5;
    mem_rdata = DR;
    cache_req(1'b0, 16'h1000, DA, w);
    cache_idle();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mainMaccess) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("rmiss_drain_started", 256'(seen), 256'(1));
    cache_req(1'b1, 16'h2000, '0, w);
    check_eq("rmiss_data", cacheRblock, DR);
    check_eq("rmiss_mem_low", 256'({mainMaccess, mainRead}), 256'(0));
    check_eq("rmiss_count", 256'(count), 256'(0));
    expect_op("rmiss_first", 1'b0, 16'h1000, DA);
    expect_op("rmiss_second", 1'b1, 16'h2000, '0);
    cache_idle();

    // Reset during MEM_RD with one entry queued.
    mem_lat = 20;
    cache_req(1'b0, 16'h4000, DB, w);
    cacheRead    = 1'b1;
    cacheWrite   = 1'b0;
    cacheAddress = 16'h3000;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mainRead) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("rst_rd_started", 256'(seen), 256'(1));
    check_eq("rst_rd_count", 256'(count), 256'(1));
    reset = 1'b1;
    cache_idle();
    @(negedge clk);
    check_eq("midrst_main_ctl", 256'({mainMaccess, mainRead, mainWrite}), 256'(0));
    check_eq("midrst_ready", 256'(cacheReady), 256'(0));
    check_eq("midrst_count", 256'(count), 256'(0));
    check_eq("midrst_empty", 256'(empty), 256'(1));
    reset   = 1'b0;
    mem_lat = 2;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | mainMaccess | cacheReady;
    end
    check_eq("midrst_quiet", 256'(seen), 256'(0));
    check_eq("midrst_no_ops", 256'(op_addr.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/write_back_buffer.md
# write_back_buffer

Decoupling buffer between the 2-way set-associative `Cache` and `MainMemory`. It absorbs evicted dirty 256-bit blocks so the cache can continue with its refill read, then drains them to main memory in the background. Cache reads are checked against the buffered entries: a matching entry is returned directly, and a miss is forwarded to memory. Cache-side and memory-side handshakes use the same `Maccess`/`Read`/`Write`/`Mready` style as the existing blocks.

## Interface
Parameters:
- `DEPTH`, 4: number of block entries, 2..8.
- `ADDR_W`, 16: byte address width.
- `OFFSET_W`, 5: block offset bits (32-byte block).
- `BLOCK_W`, 256: block data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cacheAccess` in 1: cache request valid; held until `cacheReady`.
- `cacheRead` in 1: request is a block read.
- `cacheWrite` in 1: request is a write-back (eviction).
- `cacheAddress` in ADDR_W: request byte address; only `[ADDR_W-1:OFFSET_W]` (block address) is used.
- `cacheWblock` in BLOCK_W: write-back data.
- `cacheRblock` out BLOCK_W: read data, valid while `cacheReady`=1.
- `cacheReady` out 1: one-cycle completion pulse.
- `mainMaccess` out 1: memory request valid.
- `mainRead` out 1: memory read.
- `mainWrite` out 1: memory write.
- `mainAddress` out ADDR_W: block address, offset bits forced to 0.
- `mainWblock` out BLOCK_W: drain data.
- `mainRblock` in BLOCK_W: memory read data, valid with `mainMready`.
- `mainMready` in 1: one-cycle memory completion pulse.
- `count` out $clog2(DEPTH+1): occupied entries.
- `empty` out 1: `count`==0.

## Operation
- Storage: circular FIFO of {valid, block address, data}, with head/tail pointers and a count. At most one valid entry exists per block address.
- FSM states: IDLE, MEM_RD, MEM_WR, RESP.
- Cache requests are sampled only in IDLE. Requests with `cacheRead`=`cacheWrite` or with both high are ignored.
- IDLE, write, address matches an entry: overwrite that entry's data in place (merge, count unchanged) -> RESP. Merging is allowed when full.
- IDLE, write, no match, not full: enqueue at tail, count+1 -> RESP.
- IDLE, write, no match, full: start draining the head -> MEM_WR. The request stays pending.
- IDLE, read, match: `cacheRblock`<=entry data -> RESP. No memory access.
- IDLE, read, no match: -> MEM_RD. Bypassing queued writes is safe because the addresses differ.
- IDLE, no request, not empty: drain the head -> MEM_WR.
- MEM_RD: hold `mainMaccess`=`mainRead`=1 until `mainMready`. Then capture `mainRblock` into `cacheRblock` -> RESP.
- MEM_WR: hold `mainMaccess`=`mainWrite`=1 with the head address and data until `mainMready`. Then pop the head (count-1) -> IDLE.
- RESP: `cacheReady`=1 for exactly one cycle -> IDLE.
- A drain in progress is never aborted. Cache requests wait for it, so the head is never modified mid-drain.
- Pointers wrap modulo DEPTH. The count never exceeds DEPTH or goes below 0.

## Timing
- All outputs are registered.
- Reset values: every output is 0, `empty`=1. Pointers, count and valid bits are 0; state is IDLE.
- Reset mid-operation discards all entries and in-flight requests. The next cycle shows reset values.
- Write accept or read hit: request sampled in IDLE at edge N; `cacheReady`=1 in cycle N+1 (2-cycle round trip).
- Read miss: request sampled at edge N; `mainMaccess` rises in N+1. `mainMready` is sampled at edge M; memory signals fall in M+1, and `cacheReady` with data is high in M+1.
- Drain: `mainMaccess` rises the cycle after IDLE decides to drain. It falls, and count decrements, in the cycle after `mainMready`.
- The cache must drop `cacheAccess` at the edge ending the `cacheReady` cycle. IDLE never re-samples a completed request.
- `mainMready` outside MEM_RD/MEM_WR is ignored.

## Structure
- The shared package/header holds:
  - the FSM state encodings (IDLE=0, MEM_RD=1, MEM_WR=2, RESP=3);
  - the `OFFSET_W` and `BLOCK_W` defaults, shared with `Cache` and `MainMemory`.
- One sub-module, `wb_entry_store`, contains:
  - entry registers, pointers and count;
  - the parallel address match, returning a hit flag, index and data;
  - enqueue, merge and pop ports.
- `write_back_buffer` wraps `wb_entry_store` with the FSM and handshake logic.

## Test plan
- Reset then idle: all outputs 0, `empty`=1, `count`=0; `mainMaccess` stays 0 for 10 cycles.
- Write block addr 0x1000 data A with a 5-cycle memory latency: `cacheReady` 1 cycle after sampling, `count`=1. Drain then writes A to 0x1000 and `count` returns to 0.
- Write 0x1000=A, then read 0x1000 before the drain: `cacheRblock`=A two cycles after the request, with no `mainRead`.
- Write 0x1000=A, then 0x1000=B: `count` stays 1, and the drain writes only B.
- Fill 4 distinct addresses, then a 5th write: the 5th waits for one drain (`mainWrite` to the first address), then is accepted; `count`=4. Pointer wrap is checked across 12 writes.
- Read 0x2000 (miss) while a drain is in flight: the drain completes first, then `mainRead` 0x2000, then `cacheRblock`=`mainRblock` with `cacheReady`. A reset asserted during MEM_RD clears everything.
